// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler
// Round-robin DRP reader for the XADC aux channels. Each end-of-conversion
// starts one DRP read of the next channel in CH_ADDRS. Each channel keeps its
// latest 16-bit result. An optional deadband stops small code changes from
// rewriting a channel register. A read that gets no drdy within TIMEOUT cycles
// is abandoned and counted in a saturating error counter.
module xadc_drp_scheduler #(
  parameter int          NUM_CH   = 4,
  parameter logic [63:0] CH_ADDRS = 64'h0000_001F_1716_1514,
  parameter int          HYST     = 0,
  parameter int          TIMEOUT  = 63
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_eoc,
  output logic [6:0]            o_daddr,
  output logic                  o_den,
  input  logic [15:0]           i_drp_do,
  input  logic                  i_drp_drdy,
  output logic [16*NUM_CH-1:0]  o_ch_data,
  output logic                  o_upd_vld,
  output logic [2:0]            o_upd_ch,
  output logic [7:0]            o_err_cnt
);

  localparam int             IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_CH - 1);
  localparam logic [15:0]    TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [12:0]    HYST_C   = 13'(HYST);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STORE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_next;
  logic              pending;
  logic [15:0]       timer;
  logic [15:0]       cap;
  logic [15:0]       ch_q [NUM_CH];
  logic [NUM_CH-1:0] written;

  logic              drdy_hit;
  logic              timeout_hit;
  logic [11:0]       new_code;
  logic [11:0]       old_code;
  logic [11:0]       diff;
  logic              do_update;

  // Read-completion events, next channel index and the deadband decision
  always_comb begin
    drdy_hit    = (state == WAIT) && i_drp_drdy;
    timeout_hit = (state == WAIT) && !i_drp_drdy && (timer == TMO_LAST);
    idx_next    = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    new_code    = cap[15:4];
    old_code    = ch_q[idx][15:4];
    diff        = (new_code >= old_code) ? (new_code - old_code) : (old_code - new_code);
    do_update   = !written[idx] || (HYST == 0) || ({1'b0, diff} >= HYST_C);
  end

  // Next-state logic; den is asserted only while in REQ
  always_comb begin
    state_nxt = state;
    o_den     = 1'b0;
    case (state)
      IDLE: begin
        if (i_eoc || pending) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        o_den     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (i_drp_drdy) begin
          state_nxt = STORE;
        end else if (timer == TMO_LAST) begin
          state_nxt = IDLE;
        end
      end
      STORE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transaction control: one-deep eoc memory, address latch, wait timer, data capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending <= 1'b0;
      o_daddr <= '0;
      timer   <= '0;
      cap     <= '0;
    end else begin
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (i_eoc) begin
        pending <= 1'b1;
      end
      if ((state == IDLE) && (state_nxt == REQ)) begin
        o_daddr <= CH_ADDRS[8*int'(idx) +: 7];
      end
      if (state == REQ) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 16'd1;
      end
      if (drdy_hit) begin
        cap <= i_drp_do;
      end
    end
  end

  // Channel index advance and saturating timeout counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx       <= '0;
      o_err_cnt <= '0;
    end else begin
      if (timeout_hit) begin
        if (o_err_cnt != 8'hFF) begin
          o_err_cnt <= o_err_cnt + 8'd1;
        end
        idx <= idx_next;
      end else if (state == STORE) begin
        idx <= idx_next;
      end
    end
  end

  // Channel result registers, first-write flags and the update strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ch_q[k] <= '0;
      end
      written   <= '0;
      o_upd_vld <= 1'b0;
      o_upd_ch  <= '0;
    end else begin
      o_upd_vld <= 1'b0;
      if ((state == STORE) && do_update) begin
        ch_q[idx]    <= cap;
        written[idx] <= 1'b1;
        o_upd_vld    <= 1'b1;
        o_upd_ch     <= 3'(idx);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign o_ch_data[16*k +: 16] = ch_q[k];
  end

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// tb_xadc_drp_scheduler
// Directed bench with a DRP responder model and two scoreboards: expected
// reads (address, channel, returned data) and expected channel updates.
module tb_xadc_drp_scheduler;

  localparam int NUM_CH  = 4;
  localparam int HYST    = 4;
  localparam int TIMEOUT = 63;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  eoc;
  logic [6:0]            daddr;
  logic                  den;
  logic [15:0]           drp_do;
  logic                  drdy;
  logic [16*NUM_CH-1:0]  ch_data;
  logic                  upd_vld;
  logic [2:0]            upd_ch;
  logic [7:0]            err_cnt;

  typedef struct {
    logic [6:0]  addr;
    int          ch;
    logic [15:0] data;
    bit          respond;
  } rd_t;

  typedef struct {
    int          ch;
    logic [15:0] data;
  } upd_t;

  rd_t         rd_q[$];
  upd_t        upd_q[$];
  int          num_checks = 0;
  int          num_errors = 0;
  logic [15:0] m_data [NUM_CH];
  bit          m_written [NUM_CH];
  int          m_err;
  int          drdy_cd;
  int          upd_cd;
  bit          resp_live;
  int          resp_ch;
  logic [15:0] resp_data;

  xadc_drp_scheduler #(
    .NUM_CH (NUM_CH),
    .HYST   (HYST),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_eoc     (eoc),
    .o_daddr   (daddr),
    .o_den     (den),
    .i_drp_do  (drp_do),
    .i_drp_drdy(drdy),
    .o_ch_data (ch_data),
    .o_upd_vld (upd_vld),
    .o_upd_ch  (upd_ch),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_data[k]    = '0;
      m_written[k] = 1'b0;
    end
    m_err     = 0;
    resp_live = 1'b0;
    upd_cd    = 0;
    upd_q.delete();
  endtask

  task automatic pushRead(input logic [6:0] addr, input int ch, input logic [15:0] data, input bit respond);
    rd_t r;
    r.addr    = addr;
    r.ch      = ch;
    r.data    = data;
    r.respond = respond;
    rd_q.push_back(r);
  endtask

  // One cycle at the falling edge: check outputs, run the DRP model, drive inputs
  task automatic tick(input logic eoc_v, input logic rst_v);
    bit   upd_now;
    bit   drdy_fire;
    rd_t  r;
    upd_t u;
    int   newc;
    int   oldc;
    int   d;
    upd_now   = 1'b0;
    drdy_fire = 1'b0;
    if (upd_cd > 0) begin
      upd_cd--;
      if (upd_cd == 0) upd_now = 1'b1;
    end
    if (drdy_cd > 0) begin
      drdy_cd--;
      if (drdy_cd == 0) drdy_fire = 1'b1;
    end
    if (den === 1'b1) begin
      checkOutput("den_expected", 64'(rd_q.size() > 0), 64'd1);
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        checkOutput("daddr", 64'(daddr), 64'(r.addr));
        if (r.respond) begin
          drdy_cd   = 3;
          resp_live = 1'b1;
          resp_ch   = r.ch;
          resp_data = r.data;
        end
      end
    end
    if ((upd_vld === 1'b1) || upd_now) begin
      checkOutput("upd_vld", 64'(upd_vld), 64'(upd_now));
      if (upd_now) begin
        u = upd_q.pop_front();
        checkOutput("upd_ch", 64'(upd_ch), 64'(u.ch));
        checkOutput("upd_slot", 64'(ch_data[16*u.ch +: 16]), 64'(u.data));
      end
    end
    if (rst_v) modelReset();
    drdy   = 1'b0;
    drp_do = 16'hDEAD;
    if (drdy_fire) begin
      drdy   = 1'b1;
      drp_do = resp_data;
      if (resp_live) begin
        newc = int'(resp_data[15:4]);
        oldc = int'(m_data[resp_ch][15:4]);
        d    = (newc > oldc) ? (newc - oldc) : (oldc - newc);
        if (!m_written[resp_ch] || (HYST == 0) || (d >= HYST)) begin
          m_data[resp_ch]    = resp_data;
          m_written[resp_ch] = 1'b1;
          u.ch   = resp_ch;
          u.data = resp_data;
          upd_q.push_back(u);
          upd_cd = 2;
        end
        resp_live = 1'b0;
      end
    end
    rst = rst_v;
    eoc = eoc_v;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic eoc_first, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick((i == 0) ? eoc_first : 1'b0, 1'b0);
    end
  endtask

  task automatic checkSlots(input string tag);
    for (int k = 0; k < NUM_CH; k++) begin
      checkOutput(tag, 64'(ch_data[16*k +: 16]), 64'(m_data[k]));
    end
  endtask

  initial begin
    rst     = 1'b1;
    eoc     = 1'b0;
    drdy    = 1'b0;
    drp_do  = '0;
    drdy_cd = 0;
    modelReset();
    repeat (3) @(negedge clk);

    checkOutput("rst_daddr", 64'(daddr), 64'd0);
    checkOutput("rst_den", 64'(den), 64'd0);
    checkOutput("rst_ch_data", 64'(ch_data), 64'd0);
    checkOutput("rst_upd_vld", 64'(upd_vld), 64'd0);
    checkOutput("rst_upd_ch", 64'(upd_ch), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
    applyStimulus(1'b0, 4);

    for (int k = 0; k < NUM_CH; k++) begin
      pushRead(7'(8'h14 + k), k, 16'(16'hA5A0 + k), 1'b1);
      applyStimulus(1'b1, 20);
    end
    checkSlots("first_pass_slot");
    checkOutput("first_pass_slot3", 64'(ch_data[63:48]), 64'h0000_0000_0000_A5A3);

    pushRead(7'h14, 0, 16'h8000, 1'b1);
    applyStimulus(1'b1, 20);

    pushRead(7'h15, 1, 16'h1230, 1'b1);
    pushRead(7'h16, 2, 16'h4560, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    applyStimulus(1'b0, 40);
    checkOutput("b2b_reads_done", 64'(rd_q.size()), 64'd0);
    checkSlots("b2b_slot");

    pushRead(7'h17, 3, 16'h0000, 1'b0);
    tick(1'b1, 1'b0);
    repeat (TIMEOUT) tick(1'b0, 1'b0);
    checkOutput("err_before_timeout", 64'(err_cnt), 64'd0);
    tick(1'b0, 1'b0);
    checkOutput("err_after_timeout", 64'(err_cnt), 64'd1);
    m_err = 1;
    applyStimulus(1'b0, 4);

    pushRead(7'h14, 0, 16'h8020, 1'b1);
    applyStimulus(1'b1, 20);
    checkOutput("hyst_hold_slot0", 64'(ch_data[15:0]), 64'h8000);
    pushRead(7'h15, 1, 16'h1231, 1'b1);
    applyStimulus(1'b1, 20);
    pushRead(7'h16, 2, 16'h4568, 1'b1);
    applyStimulus(1'b1, 20);
    pushRead(7'h17, 3, 16'hFFF0, 1'b1);
    applyStimulus(1'b1, 20);
    pushRead(7'h14, 0, 16'h8050, 1'b1);
    applyStimulus(1'b1, 20);
    checkSlots("hyst_slot");
    checkOutput("hyst_err", 64'(err_cnt), 64'(m_err));

    pushRead(7'h15, 1, 16'h7770, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    applyStimulus(1'b0, 20);
    checkSlots("post_rst_slot");
    checkOutput("post_rst_err", 64'(err_cnt), 64'd0);
    checkOutput("post_rst_upd_ch", 64'(upd_ch), 64'd0);
    pushRead(7'h14, 0, 16'h0010, 1'b1);
    applyStimulus(1'b1, 20);
    checkSlots("post_rst_read_slot");

    for (int i = 0; i < 300; i++) begin
      pushRead(7'(8'h14 + ((1 + i) % NUM_CH)), (1 + i) % NUM_CH, 16'h0000, 1'b0);
      applyStimulus(1'b1, TIMEOUT + 3);
      if (m_err < 255) m_err++;
      if (i == 254) checkOutput("err_at_255", 64'(err_cnt), 64'(m_err));
    end
    checkOutput("err_saturated", 64'(err_cnt), 64'(m_err));
    checkOutput("all_reads_done", 64'(rd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
